// File: rtl/pspin_match_cfg_pkg.sv
// Shared constants for the PsPIN match-rule configuration block: register map,
// CTRL bit positions and commit FSM encoding.
package pspin_match_cfg_pkg;

   localparam int CTRL_OFF      = 'h000;
   localparam int COMMIT_OFF    = 'h004;
   localparam int MATCHED_OFF   = 'h008;
   localparam int UNMATCHED_OFF = 'h00C;
   localparam int RULE_BASE     = 'h100;
   localparam int RULE_STRIDE   = 16;

   localparam int RULE_IDX_OFF   = 'h0;
   localparam int RULE_MASK_OFF  = 'h4;
   localparam int RULE_START_OFF = 'h8;
   localparam int RULE_END_OFF   = 'hC;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_BIT = 1;
   localparam int CTRL_CLR_BIT  = 2;
   localparam int COMMIT_REQ_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_BND = 2'd1,
      ST_APPLY    = 2'd2
   } commit_state_e;

endpackage

// File: rtl/pspin_match_cfg_frame_mon.sv
// Snoops one AXI-stream output: tracks whether a frame is in flight and counts
// completed frames, with a clear that takes priority over a coincident frame end.
module pspin_axis_frame_mon (
   input  logic        clk,
   input  logic        rst,
   input  logic        tvalid,
   input  logic        tready,
   input  logic        tlast,
   input  logic        clr,
   output logic        in_frame,
   output logic [31:0] count
);

   logic beat;
   assign beat = tvalid && tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_frame <= 1'b0;
         count    <= '0;
      end else begin
         if (beat)
            in_frame <= !tlast;
         if (clr)
            count <= '0;
         else if (beat && tlast)
            count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/pspin_match_cfg.sv
// Host configuration controller for the PsPIN match engine: shadow rule registers,
// atomic commit at a frame boundary on both engine outputs, and frame counters.
module pspin_match_cfg
   import pspin_match_cfg_pkg::*;
#(
   parameter int UMATCH_WIDTH   = 32,
   parameter int UMATCH_ENTRIES = 16,
   parameter int UMATCH_MODES   = 2,
   parameter int REG_ADDR_WIDTH = 10,
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_STRB_WIDTH = REG_DATA_WIDTH/8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [REG_ADDR_WIDTH-1:0]              reg_wr_addr,
   input  logic [REG_DATA_WIDTH-1:0]              reg_wr_data,
   input  logic [REG_STRB_WIDTH-1:0]              reg_wr_strb,
   input  logic                                   reg_wr_en,
   output logic                                   reg_wr_wait,
   output logic                                   reg_wr_ack,
   input  logic [REG_ADDR_WIDTH-1:0]              reg_rd_addr,
   input  logic                                   reg_rd_en,
   output logic [REG_DATA_WIDTH-1:0]              reg_rd_data,
   output logic                                   reg_rd_wait,
   output logic                                   reg_rd_ack,
   input  logic                                   nic_tvalid,
   input  logic                                   nic_tready,
   input  logic                                   nic_tlast,
   input  logic                                   pspin_tvalid,
   input  logic                                   pspin_tready,
   input  logic                                   pspin_tlast,
   output logic [$clog2(UMATCH_MODES)-1:0]        match_mode,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_idx,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_mask,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_start,
   output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_end,
   output logic                                   match_valid,
   output logic                                   commit_pending
);

   localparam int MODE_W = $clog2(UMATCH_MODES);
   localparam int IDX_W  = $clog2(UMATCH_ENTRIES);
   localparam int AW     = REG_ADDR_WIDTH;
   localparam logic [AW-1:0] RULE_LO = AW'(RULE_BASE);
   localparam logic [AW-1:0] RULE_HI = AW'(RULE_BASE + UMATCH_ENTRIES*RULE_STRIDE);

   function automatic logic [REG_DATA_WIDTH-1:0] apply_strb(
      input logic [REG_DATA_WIDTH-1:0] old_d,
      input logic [REG_DATA_WIDTH-1:0] new_d,
      input logic [REG_STRB_WIDTH-1:0] strb
   );
      logic [REG_DATA_WIDTH-1:0] r;
      r = old_d;
      for (int b = 0; b < REG_STRB_WIDTH; b++)
         if (strb[b])
            r[b*8 +: 8] = new_d[b*8 +: 8];
      return r;
   endfunction

   logic [UMATCH_WIDTH-1:0] sh_idx   [UMATCH_ENTRIES];
   logic [UMATCH_WIDTH-1:0] sh_mask  [UMATCH_ENTRIES];
   logic [UMATCH_WIDTH-1:0] sh_start [UMATCH_ENTRIES];
   logic [UMATCH_WIDTH-1:0] sh_end   [UMATCH_ENTRIES];
   logic                    sh_enable;
   logic                    sh_mode;

   commit_state_e state, state_nxt;
   logic          apply;
   logic [15:0]   commit_cnt;

   logic        nic_in_frame, pspin_in_frame;
   logic [31:0] nic_count, pspin_count;
   logic        cnt_clr;

   // Word-aligned address decode for both ports
   logic [AW-1:0]    wr_wa, rd_wa, wr_off, rd_off;
   logic             wr_in_rule, rd_in_rule;
   logic [IDX_W-1:0] wr_sel, rd_sel;
   logic [3:0]       wr_fo, rd_fo;
   logic             wr_ctrl, wr_commit, commit_req;

   assign wr_wa      = {reg_wr_addr[AW-1:2], 2'b00};
   assign rd_wa      = {reg_rd_addr[AW-1:2], 2'b00};
   assign wr_off     = wr_wa - RULE_LO;
   assign rd_off     = rd_wa - RULE_LO;
   assign wr_in_rule = (wr_wa >= RULE_LO) && (wr_wa < RULE_HI);
   assign rd_in_rule = (rd_wa >= RULE_LO) && (rd_wa < RULE_HI);
   assign wr_sel     = wr_off[4 +: IDX_W];
   assign rd_sel     = rd_off[4 +: IDX_W];
   assign wr_fo      = wr_off[3:0];
   assign rd_fo      = rd_off[3:0];
   assign wr_ctrl    = (wr_wa == AW'(CTRL_OFF));
   assign wr_commit  = (wr_wa == AW'(COMMIT_OFF));
   assign commit_req = reg_wr_en && wr_commit && reg_wr_strb[0] && reg_wr_data[COMMIT_REQ_BIT];
   assign cnt_clr    = reg_wr_en && wr_ctrl && reg_wr_strb[0] && reg_wr_data[CTRL_CLR_BIT];

   logic unused_bits;
   assign unused_bits = ^{wr_off, rd_off, reg_wr_addr[1:0], reg_rd_addr[1:0]};

   assign reg_wr_wait = 1'b0;
   assign reg_rd_wait = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_enable <= 1'b0;
         sh_mode   <= 1'b0;
         for (int i = 0; i < UMATCH_ENTRIES; i++) begin
            sh_idx[i]   <= '0;
            sh_mask[i]  <= '0;
            sh_start[i] <= '0;
            sh_end[i]   <= '0;
         end
      end else if (reg_wr_en) begin
         if (wr_ctrl && reg_wr_strb[0]) begin
            sh_enable <= reg_wr_data[CTRL_EN_BIT];
            sh_mode   <= reg_wr_data[CTRL_MODE_BIT];
         end
         if (wr_in_rule) begin
            case (wr_fo)
               4'(RULE_IDX_OFF):   sh_idx[wr_sel]   <= apply_strb(sh_idx[wr_sel],   reg_wr_data, reg_wr_strb);
               4'(RULE_MASK_OFF):  sh_mask[wr_sel]  <= apply_strb(sh_mask[wr_sel],  reg_wr_data, reg_wr_strb);
               4'(RULE_START_OFF): sh_start[wr_sel] <= apply_strb(sh_start[wr_sel], reg_wr_data, reg_wr_strb);
               4'(RULE_END_OFF):   sh_end[wr_sel]   <= apply_strb(sh_end[wr_sel],   reg_wr_data, reg_wr_strb);
               default: ;
            endcase
         end
      end
   end

   logic [REG_DATA_WIDTH-1:0] rd_val;

   always_comb begin
      rd_val = '0;
      case (rd_wa)
         AW'(CTRL_OFF): begin
            rd_val[CTRL_EN_BIT]   = sh_enable;
            rd_val[CTRL_MODE_BIT] = sh_mode;
         end
         AW'(COMMIT_OFF): begin
            rd_val[COMMIT_REQ_BIT] = commit_pending;
            rd_val[31:16]          = commit_cnt;
         end
         AW'(MATCHED_OFF):   rd_val = pspin_count;
         AW'(UNMATCHED_OFF): rd_val = nic_count;
         default: begin
            if (rd_in_rule) begin
               case (rd_fo)
                  4'(RULE_IDX_OFF):   rd_val = sh_idx[rd_sel];
                  4'(RULE_MASK_OFF):  rd_val = sh_mask[rd_sel];
                  4'(RULE_START_OFF): rd_val = sh_start[rd_sel];
                  4'(RULE_END_OFF):   rd_val = sh_end[rd_sel];
                  default:            rd_val = '0;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_wr_ack  <= 1'b0;
         reg_rd_ack  <= 1'b0;
         reg_rd_data <= '0;
      end else begin
         reg_wr_ack  <= reg_wr_en;
         reg_rd_ack  <= reg_rd_en;
         reg_rd_data <= reg_rd_en ? rd_val : '0;
      end
   end

   // Commit FSM: a boundary needs both streams idle and outside a frame
   logic boundary;
   assign boundary = !nic_in_frame && !pspin_in_frame &&
                     !(nic_tvalid && nic_tready) && !(pspin_tvalid && pspin_tready);

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (commit_req) state_nxt = ST_WAIT_BND;
         ST_WAIT_BND: if (boundary)   state_nxt = ST_APPLY;
         ST_APPLY:    state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      apply          = (state == ST_APPLY);
      commit_pending = (state == ST_WAIT_BND) || (state == ST_APPLY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         match_idx   <= '0;
         match_mask  <= '0;
         match_start <= '0;
         match_end   <= '0;
         match_valid <= 1'b0;
         match_mode  <= '0;
         commit_cnt  <= '0;
      end else if (apply) begin
         for (int i = 0; i < UMATCH_ENTRIES; i++) begin
            match_idx[i*UMATCH_WIDTH +: UMATCH_WIDTH]   <= sh_idx[i];
            match_mask[i*UMATCH_WIDTH +: UMATCH_WIDTH]  <= sh_mask[i];
            match_start[i*UMATCH_WIDTH +: UMATCH_WIDTH] <= sh_start[i];
            match_end[i*UMATCH_WIDTH +: UMATCH_WIDTH]   <= sh_end[i];
         end
         match_valid <= sh_enable;
         match_mode  <= MODE_W'(sh_mode);
         commit_cnt  <= commit_cnt + 16'd1;
      end
   end

   pspin_axis_frame_mon u_nic_mon (
      .clk      (clk),
      .rst      (rst),
      .tvalid   (nic_tvalid),
      .tready   (nic_tready),
      .tlast    (nic_tlast),
      .clr      (cnt_clr),
      .in_frame (nic_in_frame),
      .count    (nic_count)
   );

   pspin_axis_frame_mon u_pspin_mon (
      .clk      (clk),
      .rst      (rst),
      .tvalid   (pspin_tvalid),
      .tready   (pspin_tready),
      .tlast    (pspin_tlast),
      .clr      (cnt_clr),
      .in_frame (pspin_in_frame),
      .count    (pspin_count)
   );

endmodule

// File: tb/tb_pspin_match_cfg.sv
// Directed bench for pspin_match_cfg: register access, commit timing, frame
// counting, counter clear/wrap and reset during a pending commit.
module tb_pspin_match_cfg;

   localparam int W  = 32;
   localparam int N  = 16;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int SW = DW/8;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   reg_wr_addr;
   logic [DW-1:0]   reg_wr_data;
   logic [SW-1:0]   reg_wr_strb;
   logic            reg_wr_en;
   logic            reg_wr_wait;
   logic            reg_wr_ack;
   logic [AW-1:0]   reg_rd_addr;
   logic            reg_rd_en;
   logic [DW-1:0]   reg_rd_data;
   logic            reg_rd_wait;
   logic            reg_rd_ack;
   logic            nic_tvalid, nic_tready, nic_tlast;
   logic            pspin_tvalid, pspin_tready, pspin_tlast;
   logic [0:0]      match_mode;
   logic [W*N-1:0]  match_idx, match_mask, match_start, match_end;
   logic            match_valid;
   logic            commit_pending;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   pspin_match_cfg dut (
      .clk            (clk),
      .rst            (rst),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .reg_wr_strb    (reg_wr_strb),
      .reg_wr_en      (reg_wr_en),
      .reg_wr_wait    (reg_wr_wait),
      .reg_wr_ack     (reg_wr_ack),
      .reg_rd_addr    (reg_rd_addr),
      .reg_rd_en      (reg_rd_en),
      .reg_rd_data    (reg_rd_data),
      .reg_rd_wait    (reg_rd_wait),
      .reg_rd_ack     (reg_rd_ack),
      .nic_tvalid     (nic_tvalid),
      .nic_tready     (nic_tready),
      .nic_tlast      (nic_tlast),
      .pspin_tvalid   (pspin_tvalid),
      .pspin_tready   (pspin_tready),
      .pspin_tlast    (pspin_tlast),
      .match_mode     (match_mode),
      .match_idx      (match_idx),
      .match_mask     (match_mask),
      .match_start    (match_start),
      .match_end      (match_end),
      .match_valid    (match_valid),
      .commit_pending (commit_pending)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reg_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb);
      @(negedge clk);
      reg_wr_addr = addr;
      reg_wr_data = data;
      reg_wr_strb = strb;
      reg_wr_en   = 1'b1;
      @(negedge clk);
      reg_wr_en   = 1'b0;
      chk("wr_ack", reg_wr_ack, 1);
   endtask

   task automatic reg_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
      @(negedge clk);
      reg_rd_addr = addr;
      reg_rd_en   = 1'b1;
      @(negedge clk);
      reg_rd_en   = 1'b0;
      chk("rd_ack", reg_rd_ack, 1);
      data = reg_rd_data;
   endtask

   // sel 0 = nic, 1 = pspin; leaves the stream idle afterwards
   task automatic send_frame(input int sel, input int beats);
      for (int b = 0; b < beats; b++) begin
         @(negedge clk);
         if (sel == 0) begin
            nic_tvalid = 1'b1; nic_tready = 1'b1; nic_tlast = (b == beats-1);
         end else begin
            pspin_tvalid = 1'b1; pspin_tready = 1'b1; pspin_tlast = (b == beats-1);
         end
      end
      @(negedge clk);
      nic_tvalid = 1'b0; nic_tlast = 1'b0;
      pspin_tvalid = 1'b0; pspin_tlast = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
      reg_rd_addr = '0; reg_rd_en = 1'b0;
      nic_tvalid = 1'b0; nic_tready = 1'b0; nic_tlast = 1'b0;
      pspin_tvalid = 1'b0; pspin_tready = 1'b0; pspin_tlast = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_valid", match_valid, 0);
      chk("rst_pending", commit_pending, 0);
      chk("rst_rd_ack", reg_rd_ack, 0);
      reg_read(10'h000, rd); chk("rst_ctrl", rd, 0);
      reg_read(10'h008, rd); chk("rst_matched", rd, 0);
      reg_read(10'h104, rd); chk("rst_rule0_mask", rd, 0);
      @(negedge clk);
      chk("rd_ack_low", reg_rd_ack, 0);
      chk("rd_data_idle", reg_rd_data, 0);

      // Byte strobes on rule 0 idx
      reg_write(10'h100, 32'hAABBCCDD, 4'hF);
      reg_write(10'h100, 32'h11223344, 4'b0010);
      reg_read(10'h100, rd); chk("strb_merge", rd, 32'hAABB33DD);

      // Unmapped access
      reg_write(10'h040, 32'hDEADBEEF, 4'hF);
      reg_read(10'h040, rd); chk("unmapped_040", rd, 0);
      reg_read(10'h200, rd); chk("unmapped_200", rd, 0);

      // Rule 3 and commit with idle streams
      reg_write(10'h130, 32'h5,     4'hF);
      reg_write(10'h134, 32'hFFFF,  4'hF);
      reg_write(10'h138, 32'h800,   4'hF);
      reg_write(10'h13C, 32'h800,   4'hF);
      reg_write(10'h000, 32'h1,     4'hF);
      reg_write(10'h004, 32'h1,     4'hF);
      chk("c1_pend_t0", commit_pending, 1);
      chk("c1_valid_t0", match_valid, 0);
      @(negedge clk);
      chk("c1_pend_t1", commit_pending, 1);
      chk("c1_valid_t1", match_valid, 0);
      @(negedge clk);
      chk("c1_valid_t2", match_valid, 1);
      chk("c1_pend_t2", commit_pending, 0);
      chk("c1_idx3", match_idx[3*W +: W], 32'h5);
      chk("c1_mask3", match_mask[3*W +: W], 32'hFFFF);
      chk("c1_start3", match_start[3*W +: W], 32'h800);
      chk("c1_end3", match_end[3*W +: W], 32'h800);
      chk("c1_idx0", match_idx[0 +: W], 32'hAABB33DD);
      chk("c1_mode", match_mode, 0);
      reg_read(10'h004, rd); chk("c1_commit_rd", rd, 32'h0001_0000);

      // Commit held off by a pspin frame; shadow write while pending is applied
      @(negedge clk);
      pspin_tvalid = 1'b1; pspin_tready = 1'b1; pspin_tlast = 1'b0;
      @(negedge clk);
      pspin_tvalid = 1'b0;
      reg_write(10'h004, 32'h1, 4'hF);
      reg_write(10'h134, 32'hFF00, 4'hF);
      reg_write(10'h004, 32'h1, 4'hF);
      repeat (3) @(negedge clk);
      chk("c2_pend_stall", commit_pending, 1);
      chk("c2_mask_stall", match_mask[3*W +: W], 32'hFFFF);
      reg_read(10'h004, rd); chk("c2_commit_pend_rd", rd, 32'h0001_0001);
      @(negedge clk); pspin_tvalid = 1'b1; pspin_tlast = 1'b0;
      @(negedge clk); pspin_tvalid = 1'b1; pspin_tlast = 1'b0;
      @(negedge clk); pspin_tvalid = 1'b1; pspin_tlast = 1'b1;
      @(negedge clk); pspin_tvalid = 1'b0; pspin_tlast = 1'b0;
      chk("c2_mask_last", match_mask[3*W +: W], 32'hFFFF);
      chk("c2_pend_last", commit_pending, 1);
      @(negedge clk);
      chk("c2_mask_apply", match_mask[3*W +: W], 32'hFFFF);
      @(negedge clk);
      chk("c2_mask_new", match_mask[3*W +: W], 32'hFF00);
      chk("c2_pend_done", commit_pending, 0);
      repeat (3) @(negedge clk);
      reg_read(10'h004, rd); chk("c2_single_apply", rd, 32'h0002_0000);
      reg_read(10'h008, rd); chk("c2_matched", rd, 1);

      // Frame counting after a clear
      reg_write(10'h000, 32'h5, 4'hF);
      reg_read(10'h008, rd); chk("clr_matched", rd, 0);
      reg_read(10'h000, rd); chk("ctrl_clr_reads0", rd, 32'h1);
      @(negedge clk);
      nic_tvalid = 1'b1; nic_tready = 1'b0; nic_tlast = 1'b1;
      @(negedge clk);
      nic_tvalid = 1'b0; nic_tready = 1'b1; nic_tlast = 1'b0;
      send_frame(0, 1);
      send_frame(0, 2);
      send_frame(0, 5);
      send_frame(1, 1);
      send_frame(1, 3);
      reg_read(10'h00C, rd); chk("unmatched_3", rd, 3);
      reg_read(10'h008, rd); chk("matched_2", rd, 2);

      // Clear coincident with last beats on both streams; also sets shadow mode
      @(negedge clk);
      reg_wr_addr = 10'h000; reg_wr_data = 32'h7; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
      nic_tvalid = 1'b1; nic_tlast = 1'b1;
      pspin_tvalid = 1'b1; pspin_tlast = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;
      nic_tvalid = 1'b0; nic_tlast = 1'b0;
      pspin_tvalid = 1'b0; pspin_tlast = 1'b0;
      chk("clr_wr_ack", reg_wr_ack, 1);
      reg_read(10'h00C, rd); chk("clr_win_unmatched", rd, 0);
      reg_read(10'h008, rd); chk("clr_win_matched", rd, 0);
      reg_read(10'h000, rd); chk("ctrl_shadow_mode", rd, 32'h3);
      chk("mode_active_unchanged", match_mode, 0);

      // Counter wrap
      @(negedge clk);
      force dut.u_pspin_mon.count = 32'hFFFF_FFFF;
      #1;
      release dut.u_pspin_mon.count;
      reg_read(10'h008, rd); chk("wrap_preload", rd, 32'hFFFF_FFFF);
      send_frame(1, 1);
      reg_read(10'h008, rd); chk("wrap_zero", rd, 0);

      // Reset while waiting for a boundary
      @(negedge clk);
      nic_tvalid = 1'b1; nic_tlast = 1'b0;
      @(negedge clk);
      nic_tvalid = 1'b0;
      reg_write(10'h004, 32'h1, 4'hF);
      @(negedge clk);
      chk("rst_mid_pend_before", commit_pending, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_pend", commit_pending, 0);
      chk("rst_mid_valid", match_valid, 0);
      chk("rst_mid_idx3", match_idx[3*W +: W], 0);
      chk("rst_mid_mask3", match_mask[3*W +: W], 0);
      reg_read(10'h130, rd); chk("rst_mid_shadow", rd, 0);
      reg_write(10'h150, 32'h77, 4'hF);
      reg_write(10'h000, 32'h3, 4'hF);
      reg_write(10'h004, 32'h1, 4'hF);
      repeat (2) @(negedge clk);
      chk("post_rst_valid", match_valid, 1);
      chk("post_rst_idx5", match_idx[5*W +: W], 32'h77);
      chk("post_rst_mode", match_mode, 1);
      reg_read(10'h004, rd); chk("post_rst_count", rd, 32'h0001_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pspin_match_cfg.md
Name: pspin_match_cfg

Overview:
- Host-facing configuration controller for the PsPIN packet match engine.
- Holds a shadow copy of all match rules, written through the corundum-style register interface.
- Commits the shadow copy atomically to the engine's rule inputs, only at a frame boundary on both engine outputs.
- Snoops both engine output streams and keeps matched and unmatched frame counters for the host.

Parameters:
UMATCH_WIDTH, 32, width of one rule field; must equal the register data width.
UMATCH_ENTRIES, 16, number of rules.
UMATCH_MODES, 2, number of combine modes; only 2 is legal (0 = AND, 1 = OR).
REG_ADDR_WIDTH, 10, register byte-address width; must cover 0x100 + UMATCH_ENTRIES*16.
REG_DATA_WIDTH, 32, register data width.
REG_STRB_WIDTH, REG_DATA_WIDTH/8, byte strobes.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reg_wr_addr  in  REG_ADDR_WIDTH  write byte address
reg_wr_data  in  REG_DATA_WIDTH  write data
reg_wr_strb  in  REG_STRB_WIDTH  byte enables
reg_wr_en  in  1  write request
reg_wr_wait  out  1  tied 0
reg_wr_ack  out  1  write acknowledge
reg_rd_addr  in  REG_ADDR_WIDTH  read byte address
reg_rd_en  in  1  read request
reg_rd_data  out  REG_DATA_WIDTH  read data
reg_rd_wait  out  1  tied 0
reg_rd_ack  out  1  read acknowledge
nic_tvalid, nic_tready, nic_tlast  in  1 each  snoop of engine unmatched output
pspin_tvalid, pspin_tready, pspin_tlast  in  1 each  snoop of engine matched output
match_mode  out  $clog2(UMATCH_MODES)  active combine mode
match_idx, match_mask, match_start, match_end  out  UMATCH_WIDTH*UMATCH_ENTRIES each  active rules; rule i at [i*UMATCH_WIDTH +: UMATCH_WIDTH]
match_valid  out  1  active rule set enabled
commit_pending  out  1  a commit is waiting for a boundary

Behaviour:
Register map (byte offsets):
- 0x000 CTRL rw: bit0 enable, bit1 mode (shadow values); bit2 write-1 clears both counters, reads 0.
- 0x004 COMMIT: write with bit0 = 1 requests a commit. Read returns bit0 = pending, bits 31:16 = commit count (16-bit, wraps).
- 0x008 MATCHED_FRAMES ro: 32-bit, wraps.
- 0x00C UNMATCHED_FRAMES ro: 32-bit, wraps.
- 0x100 + 16*i, rules: +0 idx, +4 mask, +8 start, +C end (shadow, rw).
- Unmapped addresses: reads return 0; writes are acked and have no effect.

Register access:
- reg_wr_ack and reg_rd_ack pulse exactly one cycle after the corresponding en is sampled.
- reg_rd_data is registered and valid with ack; it holds 0 when ack is low.
- Writes honour byte strobes.
- Reads of rule and CTRL registers return shadow values, not active values.

Frame tracking, one instance per output:
- in_frame sets on a valid&ready beat with !last.
- in_frame clears on a valid&ready beat with last.
- A valid&ready&last beat increments that stream's counter.
- Single-beat frames count and leave in_frame at 0.

Counter clear:
- A CTRL bit2 write zeroes both counters.
- If a frame ends in the same cycle as a clear, the clear wins.

Commit FSM:
- States: IDLE, WAIT_BND, APPLY.
- IDLE -> WAIT_BND on an accepted COMMIT write with bit0 = 1.
- WAIT_BND -> APPLY in any cycle where both in_frame flags are 0 and neither stream has valid&ready.
- APPLY (one cycle): copies all shadow fields, mode and enable into the active outputs on the same edge, then returns to IDLE.
- commit_pending is high in WAIT_BND and APPLY.
- Commit count increments on APPLY.
- Minimum latency: write sampled at edge T, FSM leaves WAIT_BND at T+1, active outputs change at edge T+2.
- A COMMIT write while pending is acked and ignored. A single apply occurs and uses the shadow contents at APPLY time, so shadow writes made while pending are included.
- An active stream stalls the commit indefinitely; there is no timeout.

Reset:
- All active outputs, match_valid, shadow registers, counters, in_frame flags and acks are 0; FSM goes to IDLE.
- Reset mid-commit discards the commit.
- Active outputs change only in APPLY or on reset.

Decomposition:
- Package pspin_match_cfg_pkg:
  - register offset constants: CTRL, COMMIT, MATCHED, UNMATCHED, RULE_BASE, RULE_STRIDE, field offsets;
  - commit FSM state encoding;
  - CTRL bit positions.
- Sub-module pspin_axis_frame_mon (in_frame flag plus 32-bit frame counter with clear), instantiated once for the nic stream and once for the pspin stream.

Test Plan:
- Reset, then read 0x000, 0x008 and 0x104 -> all read 0 with ack one cycle after en; match_valid = 0.
- Write rule 3 idx = 0x5, mask = 0xFFFF, start = 0x800, end = 0x800, CTRL = 0x1, then COMMIT = 1 with idle streams -> match_idx[3] = 0x5 and match_valid = 1 two edges after the commit write; pending low afterwards; COMMIT read gives count 1.
- Start a 4-beat pspin frame, issue a commit after beat 1, and write mask = 0xFF00 while pending -> outputs unchanged until the beat after tlast; applied mask = 0xFF00; only one apply occurs.
- Send 3 nic frames (1, 2, 5 beats) and 2 pspin frames -> UNMATCHED = 3 and MATCHED = 2; then write CTRL bit2 coincident with a last beat -> both counters read 0.
- Counter wrap: preload via force to 0xFFFFFFFF and send one frame -> counter reads 0.
- Assert rst in WAIT_BND -> pending 0, outputs 0; a later commit works normally.
